contatore_updown_ncifre_baseb: RTL and testbench

Synchronous up/down counter of N digits in an arbitrary base B, each digit stored in its own W-bit field (B = 10, W = 4 gives a packed BCD counter). Generalises the single-direction binary counter with a direction input, count enable, parallel load, per-digit carry/borrow chaining and a registered wrap pulse. It is the building block for decimal timers, event counters and cascaded counter chains, where one instance's `wrap` drives the next instance's `enable`.

---
 rtl/contatore_updown_ncifre_baseb.sv | 92 +++++++++
 tb/tb_contatore_updown_ncifre_baseb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/contatore_updown_ncifre_baseb.sv
// N-digit up/down counter in base B, one W-bit field per digit (B=10, W=4 is packed BCD).
// Priority reset > load > enable > hold; numero, wrap and load_err are all registered.
module contatore_updown_ncifre_baseb #(
    parameter int N = 4,
    parameter int B = 10,
    parameter int W = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           up_down,
    input  logic           load,
    input  logic [N*W-1:0] load_value,
    output logic [N*W-1:0] numero,
    output logic           wrap,
    output logic           load_err
);

    generate
        if (N < 1 || B < 2 || B > 2**W) begin : g_bad_param
            $error("contatore_updown_ncifre_baseb: illegal N/B/W combination");
        end
    endgenerate

    localparam logic [W-1:0] DMAX = W'(B - 1);
    localparam logic [W:0]   BASE = (W + 1)'(B);

    logic [N*W-1:0] count_next;
    logic [N*W-1:0] load_clean;
    logic           count_wrap;
    logic           load_bad;
    logic           carry;

    // Ripple the carry/borrow from digit 0; whatever is still pending past the top digit is the wrap.
    always_comb begin
        count_next = numero;
        carry      = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (carry) begin
                if (up_down) begin
                    if (numero[i*W +: W] == DMAX) begin
                        count_next[i*W +: W] = '0;
                    end else begin
                        count_next[i*W +: W] = numero[i*W +: W] + W'(1);
                        carry = 1'b0;
                    end
                end else begin
                    if (numero[i*W +: W] == '0) begin
                        count_next[i*W +: W] = DMAX;
                    end else begin
                        count_next[i*W +: W] = numero[i*W +: W] - W'(1);
                        carry = 1'b0;
                    end
                end
            end
        end
        count_wrap = carry;
    end

    // Out-of-range load digits are forced to zero so every digit always stays below B.
    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ({1'b0, load_value[i*W +: W]} < BASE) begin
                load_clean[i*W +: W] = load_value[i*W +: W];
            end else begin
                load_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            numero   <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            numero   <= load_clean;
            wrap     <= 1'b0;
            load_err <= load_bad;
        end else if (enable) begin
            numero   <= count_next;
            wrap     <= count_wrap;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contatore_updown_ncifre_baseb.sv
// Drives three counter instances (4-digit base 10, 2-digit base 10, 2-digit base 16)
// and compares each against an integer-valued modulo-B^N reference model.
module tb_contatore_updown_ncifre_baseb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst [3];
    logic        en  [3];
    logic        ud  [3];
    logic        ld  [3];
    logic [15:0] lv  [3];

    logic [15:0] num_a;
    logic [7:0]  num_b, num_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic        err_a, err_b, err_c;

    int          nb [3] = '{10, 10, 16};
    int          nn [3] = '{4, 2, 2};
    int unsigned mval [3];
    logic        mwrap [3];
    logic        merr [3];

    int vectors = 0;
    int miscompares = 0;
    int wraps_b = 0;

    contatore_updown_ncifre_baseb #(.N(4), .B(10), .W(4)) dut_a (
        .clock(clock), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]), .load(ld[0]),
        .load_value(lv[0]), .numero(num_a), .wrap(wrap_a), .load_err(err_a));

    contatore_updown_ncifre_baseb #(.N(2), .B(10), .W(4)) dut_b (
        .clock(clock), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]), .load(ld[1]),
        .load_value(lv[1][7:0]), .numero(num_b), .wrap(wrap_b), .load_err(err_b));

    contatore_updown_ncifre_baseb #(.N(2), .B(16), .W(4)) dut_c (
        .clock(clock), .reset(rst[2]), .enable(en[2]), .up_down(ud[2]), .load(ld[2]),
        .load_value(lv[2][7:0]), .numero(num_c), .wrap(wrap_c), .load_err(err_c));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int k, input int unsigned v);
        logic [15:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < nn[k]; i++) begin
            r[i*4 +: 4] = 4'(x % nb[k]);
            x = x / nb[k];
        end
        return r;
    endfunction

    function automatic void model_step(input int k);
        int unsigned modulus = nb[k] ** nn[k];
        int unsigned v = 0;
        int unsigned p = 1;
        int unsigned d;
        logic        e = 1'b0;
        if (rst[k]) begin
            mval[k] = 0; mwrap[k] = 1'b0; merr[k] = 1'b0;
        end else if (ld[k]) begin
            for (int i = 0; i < nn[k]; i++) begin
                d = int'(lv[k][i*4 +: 4]);
                if (d >= nb[k]) begin d = 0; e = 1'b1; end
                v += d * p;
                p *= nb[k];
            end
            mval[k] = v; mwrap[k] = 1'b0; merr[k] = e;
        end else if (en[k]) begin
            merr[k] = 1'b0;
            if (ud[k]) begin
                mwrap[k] = (mval[k] == modulus - 1);
                mval[k]  = (mval[k] + 1) % modulus;
            end else begin
                mwrap[k] = (mval[k] == 0);
                mval[k]  = (mval[k] + modulus - 1) % modulus;
            end
        end else begin
            mwrap[k] = 1'b0; merr[k] = 1'b0;
        end
    endfunction

    task automatic tick();
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clock);
        #1;
        check("a_numero", num_a, enc(0, mval[0]));
        check("a_wrap", {15'd0, wrap_a}, {15'd0, mwrap[0]});
        check("a_load_err", {15'd0, err_a}, {15'd0, merr[0]});
        check("b_numero", {8'd0, num_b}, enc(1, mval[1]));
        check("b_wrap", {15'd0, wrap_b}, {15'd0, mwrap[1]});
        check("c_numero", {8'd0, num_c}, enc(2, mval[2]));
        check("c_wrap", {15'd0, wrap_c}, {15'd0, mwrap[2]});
        check("c_load_err", {15'd0, err_c}, {15'd0, merr[2]});
        if (wrap_b) wraps_b++;
    endtask

    task automatic set_a(input logic r, input logic l, input logic [15:0] v,
                         input logic e, input logic u);
        rst[0] = r; ld[0] = l; lv[0] = v; en[0] = e; ud[0] = u;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; en[k] = 1'b0; ud[k] = 1'b1; ld[k] = 1'b0; lv[k] = '0;
            mval[k] = 0; mwrap[k] = 1'b0; merr[k] = 1'b0;
        end
        #2;

        // Reset for two cycles, then hold for five
        tick(); tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("reset_hold_value", num_a, 16'h0000);

        // Up rollover
        set_a(0, 1, 16'h9998, 0, 1); tick();
        set_a(0, 0, 16'h0000, 1, 1); tick();
        check("up_9999", num_a, 16'h9999);
        tick();
        check("up_wrap_value", num_a, 16'h0000);
        check("up_wrap_pulse", {15'd0, wrap_a}, 16'd1);
        tick();
        check("up_0001", num_a, 16'h0001);
        check("up_wrap_gone", {15'd0, wrap_a}, 16'd0);

        // Down with borrow chain, then down wrap
        set_a(0, 1, 16'h1000, 0, 0); tick();
        set_a(0, 0, 16'h0000, 1, 0); tick();
        check("down_0999", num_a, 16'h0999);
        tick();
        check("down_0998", num_a, 16'h0998);
        set_a(0, 1, 16'h0000, 0, 0); tick();
        set_a(0, 0, 16'h0000, 1, 0); tick();
        check("down_wrap_value", num_a, 16'h9999);
        check("down_wrap_pulse", {15'd0, wrap_a}, 16'd1);

        // Illegal load digits
        set_a(0, 1, 16'h3A7F, 0, 1); tick();
        check("illegal_load_value", num_a, 16'h3070);
        check("illegal_load_err", {15'd0, err_a}, 16'd1);
        set_a(0, 0, 16'h0000, 1, 1); tick();
        check("after_illegal_3071", num_a, 16'h3071);
        check("after_illegal_err", {15'd0, err_a}, 16'd0);

        // Direction change across two consecutive wraps
        set_a(0, 1, 16'h9999, 0, 1); tick();
        set_a(0, 0, 16'h0000, 1, 1); tick();
        set_a(0, 0, 16'h0000, 1, 0); tick();
        check("dir_change_value", num_a, 16'h9999);
        check("dir_change_wrap", {15'd0, wrap_a}, 16'd1);

        // Priority: reset over load/enable on a wrapping edge, then load over wrapping count
        set_a(1, 1, 16'h1234, 1, 1); tick();
        check("prio_reset_value", num_a, 16'h0000);
        check("prio_reset_wrap", {15'd0, wrap_a}, 16'd0);
        set_a(0, 1, 16'h9999, 0, 1); tick();
        set_a(0, 1, 16'h1234, 1, 1); tick();
        check("prio_load_value", num_a, 16'h1234);
        check("prio_load_wrap", {15'd0, wrap_a}, 16'd0);

        // Full period on B=10 N=2, random binary-mode traffic on B=16, random everything on a
        wraps_b = 0;
        en[1] = 1'b1; ud[1] = 1'b1;
        ld[2] = 1'b1; lv[2] = 16'($urandom); tick();
        for (int i = 0; i < 400; i++) begin
            en[1] = (i < 99);
            ld[2] = ($urandom_range(0, 15) == 0);
            lv[2] = 16'($urandom);
            en[2] = ($urandom_range(0, 7) != 0);
            ud[2] = 1'($urandom);
            set_a(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0), 16'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom));
            tick();
            if (i == 98) begin
                check("b_period_wraps", 16'(wraps_b), 16'd1);
                check("b_period_end", {8'd0, num_b}, 16'h0000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
